// File: rtl/sejf_lock.sv
// Digital safe lock: four-digit BCD code entry with lockout after repeated
// wrong codes, and reprogramming of the code while the safe is open.
module sejf_lock #(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCKOUT_CYC  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_ok,
    input  logic       clr,
    input  logic       close,
    input  logic       set_mode,
    output logic       is_open,
    output logic       alarm,
    output logic       prog,
    output logic [2:0] pos,
    output logic [2:0] fails
);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROGRAM = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam logic [2:0]  MAX_FAIL_V = 3'(MAX_FAIL);
    localparam logic [15:0] TIMER_LOAD = 16'(LOCKOUT_CYC - 1);

    state_t      state_reg, state_next;
    logic [15:0] code_reg, code_next;
    logic [15:0] entry_reg, entry_next;
    logic [2:0]  pos_reg, pos_next;
    logic [2:0]  fails_reg, fails_next;
    logic [15:0] timer_reg, timer_next;
    logic        is_open_reg, alarm_reg, prog_reg;

    logic        digit_valid;
    logic [15:0] shifted;

    // Digits above 9 are not BCD and are dropped everywhere.
    assign digit_valid = digit_ok && (digit_in <= 4'd9);
    assign shifted     = {entry_reg[11:0], digit_in};

    // Next-state and datapath decisions; everything holds unless a case changes it.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        entry_next = entry_reg;
        pos_next   = pos_reg;
        fails_next = fails_reg;
        timer_next = timer_reg;
        case (state_reg)
            S_LOCKED: begin
                if (!clr && digit_valid) begin
                    entry_next = shifted;
                    pos_next   = 3'd1;
                    state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clr) begin
                    pos_next   = 3'd0;
                    state_next = S_LOCKED;
                end else if (digit_valid) begin
                    entry_next = shifted;
                    pos_next   = pos_reg + 3'd1;
                    if (pos_reg == 3'd3) begin
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                pos_next = 3'd0;
                if (entry_reg == code_reg) begin
                    fails_next = 3'd0;
                    state_next = S_OPEN;
                end else begin
                    fails_next = fails_reg + 3'd1;
                    if ((fails_reg + 3'd1) == MAX_FAIL_V) begin
                        timer_next = TIMER_LOAD;
                        state_next = S_LOCKOUT;
                    end else begin
                        state_next = S_LOCKED;
                    end
                end
            end
            S_OPEN: begin
                // close outranks set_mode when both arrive together
                if (close) begin
                    state_next = S_LOCKED;
                end else if (set_mode) begin
                    pos_next   = 3'd0;
                    state_next = S_PROGRAM;
                end
            end
            S_PROGRAM: begin
                if (clr) begin
                    pos_next   = 3'd0;
                    state_next = S_OPEN;
                end else if (digit_valid) begin
                    entry_next = shifted;
                    if (pos_reg == 3'd3) begin
                        code_next  = shifted;
                        pos_next   = 3'd0;
                        state_next = S_OPEN;
                    end else begin
                        pos_next = pos_reg + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                // deaf to every input until the timer has run out
                if (timer_reg == 16'd0) begin
                    fails_next = 3'd0;
                    state_next = S_LOCKED;
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            default: begin
                pos_next   = 3'd0;
                state_next = S_LOCKED;
            end
        endcase
    end

    // State and datapath registers; status flags decode the upcoming state so
    // they line up with the state register without a combinational output path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_LOCKED;
            code_reg    <= DEFAULT_CODE;
            entry_reg   <= 16'd0;
            pos_reg     <= 3'd0;
            fails_reg   <= 3'd0;
            timer_reg   <= 16'd0;
            is_open_reg <= 1'b0;
            alarm_reg   <= 1'b0;
            prog_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            entry_reg   <= entry_next;
            pos_reg     <= pos_next;
            fails_reg   <= fails_next;
            timer_reg   <= timer_next;
            is_open_reg <= (state_next == S_OPEN);
            alarm_reg   <= (state_next == S_LOCKOUT);
            prog_reg    <= (state_next == S_PROGRAM);
        end
    end

    assign is_open = is_open_reg;
    assign alarm   = alarm_reg;
    assign prog    = prog_reg;
    assign pos     = pos_reg;
    assign fails   = fails_reg;

endmodule

// File: tb/tb_sejf_lock.sv
// Scoreboard bench for sejf_lock: stimulus pushes the expected outputs for
// the edge it drives into a queue, and a monitor compares after that edge.
module tb_sejf_lock;

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_ok;
    logic       clr;
    logic       close;
    logic       set_mode;
    logic       is_open;
    logic       alarm;
    logic       prog;
    logic [2:0] pos;
    logic [2:0] fails;

    sejf_lock #(
        .DEFAULT_CODE(16'h1234),
        .MAX_FAIL    (3),
        .LOCKOUT_CYC (1000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .digit_in(digit_in),
        .digit_ok(digit_ok),
        .clr     (clr),
        .close   (close),
        .set_mode(set_mode),
        .is_open (is_open),
        .alarm   (alarm),
        .prog    (prog),
        .pos     (pos),
        .fails   (fails)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        string      nm;
        logic [8:0] ex;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t mon_item;
    logic [8:0] actual;

    // Edge counter used to tag each expectation with the edge it belongs to.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: after each edge, compare every expectation due by now.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            mon_item = q.pop_front();
            actual   = {is_open, alarm, prog, pos, fails};
            n_chk++;
            if (mon_item.tag != cyc || actual != mon_item.ex) begin
                n_fail++;
                $display("FAIL %s: got open=%0b alarm=%0b prog=%0b pos=%0d fails=%0d, expected open=%0b alarm=%0b prog=%0b pos=%0d fails=%0d",
                         mon_item.nm, actual[8], actual[7], actual[6], actual[5:3], actual[2:0],
                         mon_item.ex[8], mon_item.ex[7], mon_item.ex[6], mon_item.ex[5:3], mon_item.ex[2:0]);
            end else begin
                $display("ok   %s: open=%0b alarm=%0b prog=%0b pos=%0d fails=%0d",
                         mon_item.nm, actual[8], actual[7], actual[6], actual[5:3], actual[2:0]);
            end
        end
    end

    function automatic logic [8:0] ev(input logic o, input logic a, input logic p,
                                      input int ps, input int f);
        return {o, a, p, 3'(ps), 3'(f)};
    endfunction

    // Drive one cycle of inputs on the falling edge; optionally expect a result.
    task automatic step(input logic r, input logic [3:0] d, input logic ok,
                        input logic c, input logic cl, input logic sm,
                        input bit chk, input string nm, input logic [8:0] ex);
        exp_t item;
        @(negedge clk);
        rst      = r;
        digit_in = d;
        digit_ok = ok;
        clr      = c;
        close    = cl;
        set_mode = sm;
        if (chk) begin
            item.tag = cyc + 1;
            item.nm  = nm;
            item.ex  = ex;
            q.push_back(item);
        end
    endtask

    task automatic dig(input logic [3:0] d, input string nm, input logic [8:0] ex);
        step(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, nm, ex);
    endtask

    task automatic idle(input bit chk, input string nm, input logic [8:0] ex);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, chk, nm, ex);
    endtask

    // Enter 9,9,9,9 from LOCKED with f prior failures; the CHECK result is
    // supplied by the caller since it depends on whether lockout follows.
    task automatic wrong_entry(input int f, input string nm, input logic [8:0] ex);
        dig(4'd9, "w_d1", ev(0, 0, 0, 1, f));
        dig(4'd9, "w_d2", ev(0, 0, 0, 2, f));
        dig(4'd9, "w_d3", ev(0, 0, 0, 3, f));
        dig(4'd9, "w_d4", ev(0, 0, 0, 4, f));
        idle(1'b1, nm, ex);
    endtask

    initial begin
        rst = 1'b0; digit_in = 4'd0; digit_ok = 1'b0;
        clr = 1'b0; close = 1'b0; set_mode = 1'b0;

        // Reset, with a digit strobe present that must be overridden
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "", 9'd0);
        step(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "reset", ev(0, 0, 0, 0, 0));

        // Correct default code opens two edges after the 4th strobe
        dig(4'd1, "c_d1", ev(0, 0, 0, 1, 0));
        dig(4'd2, "c_d2", ev(0, 0, 0, 2, 0));
        dig(4'd3, "c_d3", ev(0, 0, 0, 3, 0));
        dig(4'd4, "c_d4", ev(0, 0, 0, 4, 0));
        idle(1'b1, "c_open", ev(1, 0, 0, 0, 0));
        dig(4'd5, "open_ign_digit", ev(1, 0, 0, 0, 0));
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "close_prio", ev(0, 0, 0, 0, 0));

        // One wrong code, then boundary cases with fails=1 outstanding
        wrong_entry(0, "wrong1", ev(0, 0, 0, 0, 1));
        dig(4'd1, "b_d1", ev(0, 0, 0, 1, 1));
        dig(4'hA, "b_nonbcd", ev(0, 0, 0, 1, 1));
        dig(4'd2, "b_d2", ev(0, 0, 0, 2, 1));
        step(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "clr_with_ok", ev(0, 0, 0, 0, 1));
        dig(4'hF, "locked_nonbcd", ev(0, 0, 0, 0, 1));
        dig(4'd1, "o_d1", ev(0, 0, 0, 1, 1));
        dig(4'd2, "o_d2", ev(0, 0, 0, 2, 1));
        dig(4'd3, "o_d3", ev(0, 0, 0, 3, 1));
        dig(4'd4, "o_d4", ev(0, 0, 0, 4, 1));
        idle(1'b1, "open_clears_fails", ev(1, 0, 0, 0, 0));

        // Programming: abort once, then load 5678
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "prog_enter", ev(0, 0, 1, 0, 0));
        dig(4'd9, "prog_d1", ev(0, 0, 1, 1, 0));
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "prog_clr", ev(1, 0, 0, 0, 0));
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "prog_enter2", ev(0, 0, 1, 0, 0));
        dig(4'd5, "p_d1", ev(0, 0, 1, 1, 0));
        dig(4'hB, "p_nonbcd", ev(0, 0, 1, 1, 0));
        dig(4'd6, "p_d2", ev(0, 0, 1, 2, 0));
        dig(4'd7, "p_d3", ev(0, 0, 1, 3, 0));
        dig(4'd8, "p_done", ev(1, 0, 0, 0, 0));
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "close", ev(0, 0, 0, 0, 0));
        dig(4'd1, "old_d1", ev(0, 0, 0, 1, 0));
        dig(4'd2, "old_d2", ev(0, 0, 0, 2, 0));
        dig(4'd3, "old_d3", ev(0, 0, 0, 3, 0));
        dig(4'd4, "old_d4", ev(0, 0, 0, 4, 0));
        idle(1'b1, "old_code_rejected", ev(0, 0, 0, 0, 1));
        dig(4'd5, "new_d1", ev(0, 0, 0, 1, 1));
        dig(4'd6, "new_d2", ev(0, 0, 0, 2, 1));
        dig(4'd7, "new_d3", ev(0, 0, 0, 3, 1));
        dig(4'd8, "new_d4", ev(0, 0, 0, 4, 1));
        idle(1'b1, "new_code_opens", ev(1, 0, 0, 0, 0));
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "close2", ev(0, 0, 0, 0, 0));

        // Lockout: alarm for exactly 1000 cycles while inputs are ignored
        wrong_entry(0, "lk_fail1", ev(0, 0, 0, 0, 1));
        wrong_entry(1, "lk_fail2", ev(0, 0, 0, 0, 2));
        wrong_entry(2, "lockout_enter", ev(0, 1, 0, 0, 3));
        for (int k = 1; k <= 1000; k++) begin
            bit act;
            bit chk;
            act = (k < 1000);
            chk = (k == 1) || (k == 500) || (k == 999) || (k == 1000);
            step(1'b1, 4'(k % 10), act, act && (k % 3 == 0), act && (k % 5 == 0),
                 act && (k % 7 == 0), chk, $sformatf("lockout_k%0d", k),
                 act ? ev(0, 1, 0, 0, 3) : ev(0, 0, 0, 0, 0));
        end
        dig(4'd5, "post_d1", ev(0, 0, 0, 1, 0));
        dig(4'd6, "post_d2", ev(0, 0, 0, 2, 0));
        dig(4'd7, "post_d3", ev(0, 0, 0, 3, 0));
        dig(4'd8, "post_d4", ev(0, 0, 0, 4, 0));
        idle(1'b1, "post_open", ev(1, 0, 0, 0, 0));
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "close3", ev(0, 0, 0, 0, 0));

        // Reset in the middle of a lockout restores the default code
        wrong_entry(0, "r_fail1", ev(0, 0, 0, 0, 1));
        wrong_entry(1, "r_fail2", ev(0, 0, 0, 0, 2));
        wrong_entry(2, "r_lockout", ev(0, 1, 0, 0, 3));
        for (int k = 1; k <= 500; k++) begin
            idle(k == 500, "r_lockout_500", ev(0, 1, 0, 0, 3));
        end
        step(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rst_in_lockout", ev(0, 0, 0, 0, 0));
        dig(4'd1, "rc_d1", ev(0, 0, 0, 1, 0));
        dig(4'd2, "rc_d2", ev(0, 0, 0, 2, 0));
        dig(4'd3, "rc_d3", ev(0, 0, 0, 3, 0));
        dig(4'd4, "rc_d4", ev(0, 0, 0, 4, 0));
        idle(1'b1, "default_code_restored", ev(1, 0, 0, 0, 0));

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
